// File: rtl/can_bit_pkg.sv
// Shared types and constants for the CAN transmit bit stuffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package can_bit_pkg;

    typedef enum logic [1:0] {
        PASS,
        COUNT,
        INSERT
    } stuff_tx_state_t;

    localparam logic DOMINANT              = 1'b0;
    localparam logic RECESSIVE             = 1'b1;
    localparam int   CAN_STUFF_LEN_DEFAULT = 5;

endpackage : can_bit_pkg

// File: rtl/can_bit_stuffer_tx.sv
// Transmit-side CAN bit stuffer: inserts a complement bit after STUFF_LEN equal bits in the stuff area.
// Latency: TX updates on the clk edge where TP is sampled high (1 clk after TP is presented).
// Backpressure: TX_READY drops on the TP that emits a stuff bit; missing data at TP forces recessive and pulses UNDERRUN.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   TP                  transmit-point strobe, one pulse per CAN bit time
//   F_STF               0 = stuffing active, 1 = no stuffing (sampled at TP only)
//   TX_DATA/TX_VALID    unstuffed bit from the frame builder
//   TX_READY            combinational; transfer = TP & TX_VALID & TX_READY
//   TX                  bus bit, 1 = recessive
//   STUFF_BIT           high while TX carries an inserted stuff bit
//   UNDERRUN            one-clk pulse when TP finds no valid bit
//   RX, BIT_ERR         only with CAN_STUFF_READBACK_EN defined: bus readback compare
module can_bit_stuffer_tx
    import can_bit_pkg::*;
#(
    parameter int STUFF_LEN = CAN_STUFF_LEN_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic TP,
    input  logic F_STF,
    input  logic TX_DATA,
    input  logic TX_VALID,
    output logic TX_READY,
    output logic TX,
    output logic STUFF_BIT,
    output logic UNDERRUN
`ifdef CAN_STUFF_READBACK_EN
    ,
    input  logic RX,
    output logic BIT_ERR
`endif
);

    localparam int CNT_W = $clog2(STUFF_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_STUF = CNT_W'(STUFF_LEN);

    stuff_tx_state_t  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             tx_q, tx_d;
    logic             stuff_q, stuff_d;
    logic             und_q, und_d;

    // Bit driven on a non-stuff TP: missing data is replaced by recessive.
    logic             send_bit;
    logic [CNT_W-1:0] run_len;

    assign send_bit = TX_VALID ? TX_DATA : RECESSIVE;
    // A change of level restarts the run; the sent bit is always its first member.
    assign run_len  = (send_bit != last_q) ? CNT_ONE : cnt_q + CNT_ONE;

    assign TX_READY  = TP & (state_q != INSERT);
    assign TX        = tx_q;
    assign STUFF_BIT = stuff_q;
    assign UNDERRUN  = und_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        tx_d    = tx_q;
        stuff_d = stuff_q;
        und_d   = 1'b0;
        if (TP) begin
            unique case (state_q)
                INSERT: begin
                    // A pending stuff bit goes out even if the stuff area just closed.
                    tx_d    = ~last_q;
                    stuff_d = 1'b1;
                    last_d  = ~last_q;
                    cnt_d   = CNT_ONE;
                    state_d = F_STF ? PASS : COUNT;
                end
                PASS: begin
                    tx_d    = send_bit;
                    stuff_d = 1'b0;
                    und_d   = ~TX_VALID;
                    last_d  = send_bit;
                    if (!F_STF) begin
                        state_d = COUNT;
                        cnt_d   = CNT_ONE;
                    end else begin
                        cnt_d   = '0;
                    end
                end
                COUNT: begin
                    tx_d    = send_bit;
                    stuff_d = 1'b0;
                    und_d   = ~TX_VALID;
                    last_d  = send_bit;
                    if (run_len == CNT_STUF) begin
                        state_d = INSERT;
                        cnt_d   = run_len;
                    end else if (F_STF) begin
                        state_d = PASS;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = run_len;
                    end
                end
                default: begin
                    state_d = PASS;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= PASS;
            cnt_q   <= '0;
            last_q  <= RECESSIVE;
            tx_q    <= RECESSIVE;
            stuff_q <= 1'b0;
            und_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            tx_q    <= tx_d;
            stuff_q <= stuff_d;
            und_q   <= und_d;
        end
    end

`ifdef CAN_STUFF_READBACK_EN
    // RX at a TP reflects the bit driven since the previous TP (still in tx_q).
    // A recessive stuff bit overwritten by a dominant bus is not an error, and the
    // reset-value bit before the first TP was never really driven.
    logic seen_q;
    logic bit_err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seen_q    <= 1'b0;
            bit_err_q <= 1'b0;
        end else begin
            bit_err_q <= TP & seen_q & (RX != tx_q) & ~(stuff_q & tx_q & ~RX);
            if (TP) begin
                seen_q <= 1'b1;
            end
        end
    end

    assign BIT_ERR = bit_err_q;
`endif

endmodule : can_bit_stuffer_tx

// File: tb/tb_can_bit_stuffer_tx.sv
// Bench for can_bit_stuffer_tx: directed scenarios plus randomized traffic against a history-based model.
// Latency: n/a.
// Backpressure: n/a.
module tb_can_bit_stuffer_tx;

    localparam int SL = 5;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic TP = 1'b0;
    logic F_STF = 1'b1;
    logic TX_DATA = 1'b1;
    logic TX_VALID = 1'b0;
    logic TX_READY;
    logic TX;
    logic STUFF_BIT;
    logic UNDERRUN;
`ifdef CAN_STUFF_READBACK_EN
    logic RX = 1'b1;
    logic BIT_ERR;
`endif

    can_bit_stuffer_tx #(.STUFF_LEN(SL)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .TP        (TP),
        .F_STF     (F_STF),
        .TX_DATA   (TX_DATA),
        .TX_VALID  (TX_VALID),
        .TX_READY  (TX_READY),
        .TX        (TX),
        .STUFF_BIT (STUFF_BIT),
        .UNDERRUN  (UNDERRUN)
`ifdef CAN_STUFF_READBACK_EN
        ,
        .RX        (RX),
        .BIT_ERR   (BIT_ERR)
`endif
    );

    initial forever #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Reference model: the stuff run is the tail of equal bits in the history of
    // bits emitted since the stuff area opened (history empty = not stuffing).
    bit m_hist[$];
    bit m_area;
    bit m_pend;
    bit m_tx;
    bit m_stf;
    bit m_und;
    bit m_berr;
    bit m_started;
    logic last_rdy;

    function automatic int tail_run();
        int n = 0;
        int i = m_hist.size() - 1;
        while (i >= 0 && m_hist[i] == m_hist[m_hist.size() - 1]) begin
            n++;
            i--;
        end
        return n;
    endfunction

    task automatic model_reset();
        m_hist.delete();
        m_area = 0; m_pend = 0; m_tx = 1; m_stf = 0; m_und = 0;
        m_berr = 0; m_started = 0;
    endtask

    task automatic model_tp(input bit valid, input bit data, input bit fstf, input bit rx);
        bit b;
        m_berr    = m_started && (rx != m_tx) && !(m_stf && m_tx && !rx);
        m_started = 1;
        if (m_pend) begin
            b = ~m_hist[m_hist.size() - 1];
            m_tx = b; m_stf = 1; m_und = 0; m_pend = 0;
            m_hist.push_back(b);
            if (fstf) begin m_area = 0; m_hist.delete(); end
        end else begin
            b = valid ? data : 1'b1;
            m_tx = b; m_stf = 0; m_und = !valid;
            if (!m_area) begin
                m_hist.delete();
                if (!fstf) begin m_area = 1; m_hist.push_back(b); end
            end else begin
                m_hist.push_back(b);
                if (tail_run() == SL) m_pend = 1;
                else if (fstf) begin m_area = 0; m_hist.delete(); end
            end
        end
        while (m_hist.size() > 32) void'(m_hist.pop_front());
    endtask

    // One clk cycle: drive at negedge, check TX_READY, then outputs #1 after posedge.
    task automatic step(input bit tp, input bit valid, input bit data, input bit fstf, input bit rx_flip);
        bit rxv;
        @(negedge clk);
        rxv      = m_tx ^ rx_flip;
        TP       = tp;
        TX_VALID = valid;
        TX_DATA  = data;
        F_STF    = fstf;
`ifdef CAN_STUFF_READBACK_EN
        RX       = rxv;
`endif
        #1;
        check("tx_ready", TX_READY, tp && !m_pend);
        last_rdy = TX_READY;
        @(posedge clk);
        if (tp) model_tp(valid, data, fstf, rxv);
        else begin m_und = 0; m_berr = 0; end
        #1;
        check("tx", TX, m_tx);
        check("stuff_bit", STUFF_BIT, m_stf);
        check("underrun", UNDERRUN, m_und);
`ifdef CAN_STUFF_READBACK_EN
        check("bit_err", BIT_ERR, m_berr);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        TP = 1'b0;
        #1;
        check("rst_tx", TX, 1'b1);
        check("rst_stuff", STUFF_BIT, 1'b0);
        check("rst_underrun", UNDERRUN, 1'b0);
        check("rst_ready", TX_READY, 1'b0);
`ifdef CAN_STUFF_READBACK_EN
        check("rst_bit_err", BIT_ERR, 1'b0);
`endif
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        bit fs;
        bit dat;
        model_reset();

        // Five-bit stuff: 0,0,0,0,0 then a stuff 1 with TX_READY low, then the held 1.
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0);
        check("five_stuff_rdy", last_rdy, 1'b0);
        check("five_stuff_tx", TX, 1'b1);
        check("five_stuff_flag", STUFF_BIT, 1'b1);
        step(1, 1, 1, 0, 0);
        check("five_after_tx", TX, 1'b1);
        check("five_after_flag", STUFF_BIT, 1'b0);

        // Stuff-bit chain: the stuff 1 plus four data 1s force a stuff 0.
        for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0);
        step(1, 1, 0, 0, 0);
        check("chain_stuff_tx", TX, 1'b0);
        check("chain_stuff_flag", STUFF_BIT, 1'b1);

        // CRC tail: stuff area closes on the 5th 1, stuff 0 still sent, then no stuffing.
        do_reset();
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 0);
        step(1, 1, 1, 1, 0);
        step(1, 1, 1, 1, 0);
        check("crc_stuff_tx", TX, 1'b0);
        check("crc_stuff_flag", STUFF_BIT, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 1, 1, 0);
            check("crc_nostuff_flag", STUFF_BIT, 1'b0);
        end

        // Underrun after four 1s: forced recessive counts, stuff 0 follows.
        do_reset();
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        check("und_pulse", UNDERRUN, 1'b1);
        check("und_tx", TX, 1'b1);
        step(0, 1, 1, 0, 0);
        check("und_clear", UNDERRUN, 1'b0);
        step(1, 1, 1, 0, 0);
        check("und_stuff_tx", TX, 1'b0);
        check("und_stuff_flag", STUFF_BIT, 1'b1);

        // Reset while a stuff bit is pending; next frame counts from zero.
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        check("post_rst_no_early_stuff", STUFF_BIT, 1'b0);
        step(1, 1, 1, 0, 0);
        check("post_rst_stuff", STUFF_BIT, 1'b1);

`ifdef CAN_STUFF_READBACK_EN
        // Readback: RX=0 on a recessive data bit is an error; on a recessive stuff bit it is not.
        do_reset();
        step(1, 1, 1, 1, 0);
        step(1, 1, 1, 1, 1);
        check("rb_data_err", BIT_ERR, 1'b1);
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        check("rb_stuff_tx", TX, 1'b1);
        step(1, 1, 0, 0, 1);
        check("rb_stuff_no_err", BIT_ERR, 1'b0);
`endif

        // Randomized traffic with runs, gaps, underruns and stuff-area changes.
        do_reset();
        fs  = 1'b0;
        dat = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15) == 0) fs = ~fs;
            if ($urandom_range(3) == 0) dat = ~dat;
            step($urandom_range(3) != 0, $urandom_range(15) != 0, dat, fs,
                 $urandom_range(7) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_can_bit_stuffer_tx
